// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W  = 32;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request fields captured on the accepting edge.
  typedef struct packed {
    logic              write;
    logic              is_byte;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // One-hot byte-lane enable for a byte access at lane sel.
  function automatic logic [3:0] lane_mask(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: byte-lane synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Write each enabled byte lane on the rising edge.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][b] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: accepts one load/store at a time, answers after a
// fixed latency, and raises stall while the pipeline must hold.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Keep the latency inside what the 3-bit counter can express.
  localparam int LAT_C = (LATENCY < LAT_MIN) ? LAT_MIN :
                         (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
  localparam logic [2:0]  CNT_INIT = (LAT_C >= 2) ? 3'(LAT_C - 2) : 3'd0;
  localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;

  logic              fault;
  logic [3:0]        arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rd_shift;

  // Next-state: latch the request in IDLE, count down in BUSY, one RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = '{write: req_write, is_byte: req_byte,
                    addr: req_addr, wdata: req_wdata};
          if (LAT_C == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and captured request; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Handshake, fault detection, load lane extraction and store lane enables.
  always_comb begin
    req_ready = (state_q == IDLE);
    stall     = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
    rsp_valid = (state_q == RESP);

    fault = (!req_q.is_byte && (req_q.addr[1:0] != 2'b00)) ||
            (req_q.addr[31:2] >= DEPTH_L);

    rd_shift  = arr_rdata >> {req_q.addr[1:0], 3'b000};
    rsp_err   = rsp_valid && fault;
    rsp_rdata = '0;
    if (rsp_valid && !fault && !req_q.write)
      rsp_rdata = req_q.is_byte ? {24'h0, rd_shift[7:0]} : arr_rdata;

    arr_we = 4'h0;
    if (rsp_valid && req_q.write && !fault)
      arr_we = req_q.is_byte ? lane_mask(req_q.addr[1:0]) : 4'hF;
    arr_wdata = req_q.is_byte ? {4{req_q.wdata[7:0]}} : req_q.wdata;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(req_q.addr[AW+1:2]),
    .wdata(arr_wdata),
    .raddr(req_q.addr[AW+1:2]),
    .rdata(arr_rdata)
  );

endmodule
